// File: rtl/bus_legalize_stage.sv
// Legalizing feeder for 8-bit cell input buses: ties off unknown bits, buffers
// the cleaned words in a small FIFO and keeps a saturating count of tie-offs.
module bus_legalize_stage #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     DEPTH     = 2,
    parameter logic [WIDTH-1:0] TIE_VALUE = '0,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_known,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_fixed,
    input  logic             clr_count,
    output logic [CNT_W-1:0] fix_count
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned PCW = $clog2(WIDTH + 1);
    localparam int unsigned SW  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
    localparam int unsigned EW  = WIDTH + 1;

    function automatic logic [PCW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             full, empty, push, pop;
    logic [WIDTH-1:0] leg;
    logic             leg_fixed;
    logic [PCW-1:0]   unk_cnt;
    logic [SW-1:0]    cnt_sum;
    logic [EW-1:0]    head;

    // Unknown bits take the tie-off value; known bits pass through.
    assign leg       = (in_data & in_known) | (TIE_VALUE & ~in_known);
    assign leg_fixed = |(~in_known);
    assign unk_cnt   = popcount(~in_known);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = out_ready && !empty;

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign out_data  = empty ? '0 : head[WIDTH-1:0];
    assign out_fixed = empty ? 1'b0 : head[WIDTH];
    assign fix_count = cnt_q;

    // Next-state for pointers and the saturating tie-off counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_sum  = '0;
        cnt_d    = cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        cnt_sum = (clr_count ? SW'(0) : SW'(cnt_q)) + (push ? SW'(unk_cnt) : SW'(0));
        if (cnt_sum > SW'({CNT_W{1'b1}})) begin
            cnt_d = '1;
        end else begin
            cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; empty-gating of the outputs hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {leg_fixed, leg};
        end
    end

endmodule

// File: tb/tb_bus_legalize_stage.sv
// Bench for bus_legalize_stage: three instances (tie 0, tie FF, 3-bit counter)
// share inputs; vector table, directed corner sequences and a random run.
module tb_bus_legalize_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready, clr_count;
    logic [7:0] in_data, in_known;

    logic        r0, r1, r2, v0, v1, v2, f0, f1, f2;
    logic [7:0]  d0, d1, d2;
    logic [15:0] c0, c1;
    logic [2:0]  c2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bus_legalize_stage #(.WIDTH(8), .DEPTH(2), .TIE_VALUE(8'h00), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
        .in_known(in_known), .out_valid(v0), .out_ready(out_ready), .out_data(d0),
        .out_fixed(f0), .clr_count(clr_count), .fix_count(c0));
    bus_legalize_stage #(.WIDTH(8), .DEPTH(2), .TIE_VALUE(8'hFF), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
        .in_known(in_known), .out_valid(v1), .out_ready(out_ready), .out_data(d1),
        .out_fixed(f1), .clr_count(clr_count), .fix_count(c1));
    bus_legalize_stage #(.WIDTH(8), .DEPTH(2), .TIE_VALUE(8'h00), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_data(in_data),
        .in_known(in_known), .out_valid(v2), .out_ready(out_ready), .out_data(d2),
        .out_fixed(f2), .clr_count(clr_count), .fix_count(c2));

    typedef struct {
        logic [7:0] data;
        logic [7:0] known;
        logic [7:0] exp0;
        logic [7:0] exp1;
        logic       fixed;
        int         pc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; clr_count = 1'b0; out_ready = 1'b0;
        in_data = '0; in_known = '0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
    endtask

    function automatic logic [7:0] legal(input logic [7:0] d, input logic [7:0] k,
                                         input logic [7:0] tie);
        return (d & k) | (tie & ~k);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    vec_t tbl[5];

    initial begin
        logic [7:0] qd[$];
        logic [7:0] qk[$];
        int m0, m1, m2, cum0, cum2, pc;
        bit push, pop;

        tbl[0] = '{8'hB5, 8'hF0, 8'hB0, 8'hBF, 1'b1, 4};
        tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 0};
        tbl[2] = '{8'h3C, 8'h00, 8'h00, 8'hFF, 1'b1, 8};
        tbl[3] = '{8'hA5, 8'h0F, 8'h05, 8'hF5, 1'b1, 4};
        tbl[4] = '{8'h12, 8'hFE, 8'h12, 8'h13, 1'b1, 1};

        // Reset then idle
        do_reset();
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_data", 32'(d0), 32'h0);
        chk("rst_fixed", 32'(f0), 32'd0);
        chk("rst_ready", 32'(r0), 32'd1);
        chk("rst_count", 32'(c0), 32'd0);

        // Vector table, one word at a time with out_ready high
        out_ready = 1'b1;
        cum0 = 0; cum2 = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = tbl[i].data; in_known = tbl[i].known;
            tick();
            in_valid = 1'b0;
            cum0 += tbl[i].pc;
            cum2 = sat(cum2 + tbl[i].pc, 7);
            chk($sformatf("vec%0d_valid", i), 32'(v0), 32'd1);
            chk($sformatf("vec%0d_data_t0", i), 32'(d0), 32'(tbl[i].exp0));
            chk($sformatf("vec%0d_data_tff", i), 32'(d1), 32'(tbl[i].exp1));
            chk($sformatf("vec%0d_fixed", i), 32'(f0), 32'(tbl[i].fixed));
            chk($sformatf("vec%0d_count", i), 32'(c0), 32'(cum0));
            chk($sformatf("vec%0d_count3", i), 32'(c2), 32'(cum2));
            tick();
            chk($sformatf("vec%0d_popped", i), 32'(v0), 32'd0);
        end

        // Fill and backpressure
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; in_known = 8'hFF;
        tick();
        in_data = 8'h22;
        tick();
        chk("bp_ready_full", 32'(r0), 32'd0);
        chk("bp_head", 32'(d0), 32'h11);
        in_data = 8'h33;
        tick();
        chk("bp_head_stable", 32'(d0), 32'h11);
        chk("bp_fixed", 32'(f0), 32'd0);
        chk("bp_ready_still", 32'(r0), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_ready_pop_cycle", 32'(r0), 32'd0);
        tick();
        chk("bp_ready_after_pop", 32'(r0), 32'd1);
        chk("bp_second", 32'(d0), 32'h22);
        chk("bp_count", 32'(c0), 32'd0);
        tick();
        chk("bp_no_third", 32'(v0), 32'd0);

        // Streaming with wrap-around through the tie-FF instance
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_known = 8'hFE;
            tick();
            chk($sformatf("st%0d_data", i), 32'(d1), 32'(i | 1));
            chk($sformatf("st%0d_ready", i), 32'(r1), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("st_drained", 32'(v1), 32'd0);
        chk("st_count", 32'(c1), 32'd10);
        chk("st_count3", 32'(c2), 32'd7);

        // Counter saturation and clear
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h5A; in_known = 8'h00;
        tick();
        tick();
        in_valid = 1'b0;
        chk("sat_count3", 32'(c2), 32'd7);
        chk("sat_count16", 32'(c0), 32'd16);
        clr_count = 1'b1; in_valid = 1'b1; in_known = 8'hFC;
        tick();
        clr_count = 1'b0; in_valid = 1'b0;
        chk("clr_push_count3", 32'(c2), 32'd2);
        chk("clr_push_count16", 32'(c0), 32'd2);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        chk("clr_only", 32'(c0), 32'd0);

        // Asynchronous reset mid-operation
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h44; in_known = 8'hFF;
        tick();
        in_data = 8'h55; in_known = 8'h0F;
        tick();
        in_valid = 1'b0;
        chk("ar_buffered", 32'(v0), 32'd1);
        chk("ar_count_pre", 32'(c0), 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(v0), 32'd0);
        chk("ar_count", 32'(c0), 32'd0);
        chk("ar_ready", 32'(r0), 32'd1);
        chk("ar_data", 32'(d0), 32'h0);
        in_valid = 1'b1; in_data = 8'h66; in_known = 8'hFF;
        tick();
        chk("ar_no_accept", 32'(v0), 32'd0);
        #2 rst = 1'b0;
        in_data = 8'hAA; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ar_new_first", 32'(d0), 32'hAA);
        chk("ar_new_valid", 32'(v0), 32'd1);
        tick();
        chk("ar_drained", 32'(v0), 32'd0);

        // Random traffic against a queue model
        do_reset();
        m0 = 0; m1 = 0; m2 = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_ready", 32'(r0), 32'(qd.size() < 2));
            chk("rnd_valid", 32'(v0), 32'(qd.size() > 0));
            chk("rnd_data_t0", 32'(d0), (qd.size() > 0) ? 32'(legal(qd[0], qk[0], 8'h00)) : 32'h0);
            chk("rnd_data_tff", 32'(d1), (qd.size() > 0) ? 32'(legal(qd[0], qk[0], 8'hFF)) : 32'h0);
            chk("rnd_fixed", 32'(f0), (qd.size() > 0) ? 32'(qk[0] != 8'hFF) : 32'h0);
            chk("rnd_count16", 32'(c0), 32'(m0));
            chk("rnd_count16b", 32'(c1), 32'(m1));
            chk("rnd_count3", 32'(c2), 32'(m2));

            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_count = ($urandom_range(0, 15) == 0);
            in_data   = 8'($urandom);
            case ($urandom_range(0, 3))
                0: in_known = 8'hFF;
                1: in_known = 8'h00;
                default: in_known = 8'($urandom);
            endcase

            push = in_valid && (qd.size() < 2);
            pop  = out_ready && (qd.size() > 0);
            pc   = push ? $countones(~in_known) : 0;
            if (clr_count) begin m0 = 0; m1 = 0; m2 = 0; end
            m0 = sat(m0 + pc, 65535);
            m1 = sat(m1 + pc, 65535);
            m2 = sat(m2 + pc, 7);
            if (pop) begin
                void'(qd.pop_front());
                void'(qk.pop_front());
            end
            if (push) begin
                qd.push_back(in_data);
                qk.push_back(in_known);
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
